re_camera_ctrl: RTL and testbench

Parametrised successor to the four-pixel camera controller: sequences erase, exposure and row-by-row ADC readout for an N_ROWS pixel array with a bounded, button-adjustable exposure time. It sits between the user buttons (init, exp_incr, exp_decr) and the pixel-array/ADC control lines. It adds saturating exposure limits, an arbitrary row count, an ADC strobe position, status outputs and an optional continuous-capture mode.

---
 rtl/re_cam_pkg.sv | 17 +
 rtl/re_cam_readout.sv | 85 ++++++++
 rtl/re_camera_ctrl.sv | 133 +++++++++++++
 tb/tb_re_camera_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/re_cam_pkg.sv
// Shared definitions for the re_camera_ctrl slice: top-level state encoding
// and a counter-width helper used to size the row and slot counters.
package re_cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2,
        DONE    = 2'd3
    } cam_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/re_cam_readout.sv
// Row/slot readout sequencer. A start pulse drives row 0 low on the same
// edge; each row is held low for ADC_CYC cycles with a one-cycle ADC strobe
// at slot ADC_STROBE, and a single all-high gap separates consecutive rows.
// 'done' is combinational and high during the final slot of the last row so
// the parent can register its end-of-frame outputs on the same edge that
// releases the last row enable.
module re_cam_readout
    import re_cam_pkg::*;
#(
    parameter int N_ROWS     = 2,
    parameter int ADC_CYC    = 5,
    parameter int ADC_STROBE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [N_ROWS-1:0] nre,
    output logic              adc
);

    localparam int RW = cnt_w(N_ROWS);
    localparam int SW = cnt_w(ADC_CYC + 1);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(N_ROWS - 1);
    localparam logic [SW-1:0]     LAST_SLOT = SW'(ADC_CYC - 1);
    localparam logic [SW-1:0]     STROBE    = SW'(ADC_STROBE);
    localparam logic [N_ROWS-1:0] ROW0_BIT  = N_ROWS'(1);

    logic              r_active;
    logic              r_gap;
    logic [RW-1:0]     r_row;
    logic [SW-1:0]     r_slot;
    logic [N_ROWS-1:0] r_nre;
    logic              r_adc;

    logic              w_row_end;
    logic [RW-1:0]     w_next_row;
    logic [SW-1:0]     w_next_slot;

    assign w_row_end   = r_active && !r_gap && (r_slot == LAST_SLOT);
    assign w_next_row  = r_row + 1'b1;
    assign w_next_slot = r_slot + 1'b1;
    assign done        = w_row_end && (r_row == LAST_ROW);
    assign nre         = r_nre;
    assign adc         = r_adc;

    // Advance slot/row counters and register the row enables and ADC strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_gap    <= 1'b0;
            r_row    <= '0;
            r_slot   <= '0;
            r_nre    <= '1;
            r_adc    <= 1'b0;
        end else if (start) begin
            r_active <= 1'b1;
            r_gap    <= 1'b0;
            r_row    <= '0;
            r_slot   <= '0;
            r_nre    <= ~ROW0_BIT;
            r_adc    <= (STROBE == '0);
        end else if (r_active) begin
            if (r_gap) begin
                r_gap  <= 1'b0;
                r_row  <= w_next_row;
                r_slot <= '0;
                r_nre  <= ~(ROW0_BIT << w_next_row);
                r_adc  <= (STROBE == '0);
            end else if (w_row_end) begin
                r_nre <= '1;
                r_adc <= 1'b0;
                if (done) begin
                    r_active <= 1'b0;
                end else begin
                    r_gap <= 1'b1;
                end
            end else begin
                r_slot <= w_next_slot;
                r_adc  <= (w_next_slot == STROBE);
            end
        end
    end

endmodule

// File: rtl/re_camera_ctrl.sv
// Camera controller: erase, exposure and row-by-row ADC readout with a
// saturating, button-adjustable exposure time. The FSM here owns exposure,
// erase and status; re_cam_readout sequences the row enables and ADC strobe.
// Optional feature macro: RE_CAM_CONTINUOUS_EN (init during DONE restarts
// capture directly instead of returning to IDLE).
module re_camera_ctrl
    import re_cam_pkg::*;
#(
    parameter int N_ROWS      = 2,
    parameter int EXP_W       = 5,
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_DEFAULT = 14,
    parameter int ADC_CYC     = 5,
    parameter int ADC_STROBE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              exp_incr,
    input  logic              exp_decr,
    output logic [N_ROWS-1:0] nre,
    output logic              expose,
    output logic              erase,
    output logic              adc,
    output logic              busy,
    output logic              frame_done,
    output logic [EXP_W-1:0]  exp_time,
    output logic [1:0]        o_dbg_state
);

    localparam logic [EXP_W-1:0] EXP_LO  = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] EXP_HI  = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_RST = EXP_W'(EXP_DEFAULT);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    cam_state_t       r_state;
    logic [EXP_W-1:0] r_exp_time;
    logic [EXP_W-1:0] r_exp_cnt;
    logic             r_expose;
    logic             r_erase;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_ro_start;
    logic             w_ro_done;

    // Readout begins on the edge that ends the last exposure cycle.
    assign w_ro_start = (r_state == CAPTURE) && (r_exp_cnt == EXP_ONE);

    re_cam_readout #(
        .N_ROWS    (N_ROWS),
        .ADC_CYC   (ADC_CYC),
        .ADC_STROBE(ADC_STROBE)
    ) u_readout (
        .clk  (clk),
        .reset(reset),
        .start(w_ro_start),
        .done (w_ro_done),
        .nre  (nre),
        .adc  (adc)
    );

    assign expose      = r_expose;
    assign erase       = r_erase;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign exp_time    = r_exp_time;
    assign o_dbg_state = r_state;

    // Main FSM: exposure adjust in IDLE, timed exposure, readout wait, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_exp_time   <= EXP_RST;
            r_exp_cnt    <= '0;
            r_expose     <= 1'b0;
            r_erase      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (init) begin
                        r_state   <= CAPTURE;
                        r_exp_cnt <= r_exp_time;
                        r_expose  <= 1'b1;
                        r_erase   <= 1'b0;
                        r_busy    <= 1'b1;
                    end else if (exp_incr && !exp_decr) begin
                        if (r_exp_time < EXP_HI) r_exp_time <= r_exp_time + 1'b1;
                    end else if (exp_decr && !exp_incr) begin
                        if (r_exp_time > EXP_LO) r_exp_time <= r_exp_time - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (w_ro_start) begin
                        r_state  <= READOUT;
                        r_expose <= 1'b0;
                    end else begin
                        r_exp_cnt <= r_exp_cnt - 1'b1;
                    end
                end
                READOUT: begin
                    if (w_ro_done) begin
                        r_state      <= DONE;
                        r_frame_done <= 1'b1;
                        r_erase      <= 1'b1;
                    end
                end
                DONE: begin
                    r_frame_done <= 1'b0;
`ifdef RE_CAM_CONTINUOUS_EN
                    if (init) begin
                        r_state   <= CAPTURE;
                        r_exp_cnt <= r_exp_time;
                        r_expose  <= 1'b1;
                        r_erase   <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
`else
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_re_camera_ctrl.sv
// Self-checking bench for re_camera_ctrl (default build). Each frame pushes
// its full expected per-cycle output trace, computed from the timing
// formulas, into exp_q; an independent monitor pops one entry on every cycle
// the DUT reports busy. Exposure adjustment is checked against a saturating
// arithmetic model.
module tb_re_camera_ctrl;

    localparam int N_ROWS      = 2;
    localparam int EXP_W       = 5;
    localparam int EXP_MIN     = 2;
    localparam int EXP_MAX     = 30;
    localparam int EXP_DEFAULT = 14;
    localparam int ADC_CYC     = 5;
    localparam int ADC_STROBE  = 1;
    localparam int VW          = EXP_W + N_ROWS + 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic              exp_incr;
    logic              exp_decr;
    logic [N_ROWS-1:0] nre;
    logic              expose;
    logic              erase;
    logic              adc;
    logic              busy;
    logic              frame_done;
    logic [EXP_W-1:0]  exp_time;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int model_exp;
    bit sb_en = 1'b0;
    logic [VW-1:0] exp_q[$];

    re_camera_ctrl #(
        .N_ROWS     (N_ROWS),
        .EXP_W      (EXP_W),
        .EXP_MIN    (EXP_MIN),
        .EXP_MAX    (EXP_MAX),
        .EXP_DEFAULT(EXP_DEFAULT),
        .ADC_CYC    (ADC_CYC),
        .ADC_STROBE (ADC_STROBE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .exp_incr   (exp_incr),
        .exp_decr   (exp_decr),
        .nre        (nre),
        .expose     (expose),
        .erase      (erase),
        .adc        (adc),
        .busy       (busy),
        .frame_done (frame_done),
        .exp_time   (exp_time),
        .o_dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs in cycle k (1-based, cycle 0 = edge sampling init)
    function automatic logic [VW-1:0] model_vec(input int k, input int e);
        int t;
        int lo;
        logic [N_ROWS-1:0] nre_v;
        logic adc_v;
        t = e + N_ROWS * (ADC_CYC + 1);
        nre_v = '1;
        adc_v = 1'b0;
        for (int r = 0; r < N_ROWS; r++) begin
            lo = e + 1 + r * (ADC_CYC + 1);
            if (k >= lo && k <= lo + ADC_CYC - 1) nre_v[r] = 1'b0;
            if (k == lo + ADC_STROBE) adc_v = 1'b1;
        end
        return {EXP_W'(e), nre_v, (k <= e), (k == t), adc_v, 1'b1, (k == t)};
    endfunction

    // Scoreboard monitor: one expected entry per busy cycle
    always @(negedge clk) begin
        if (sb_en && busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: busy with no expected entry at %0t", $time);
            end else begin
                check("frame_trace",
                      32'({exp_time, nre, expose, erase, adc, busy, frame_done}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    // Driver: hold buttons in IDLE for n cycles, then check exp_time
    task automatic hold_buttons(input bit inc, input bit dec, input int n);
        exp_incr = inc;
        exp_decr = dec;
        repeat (n) begin
            @(negedge clk);
            if (inc && !dec && model_exp < EXP_MAX) model_exp++;
            if (dec && !inc && model_exp > EXP_MIN) model_exp--;
        end
        check("exp_adjust", 32'(exp_time), 32'(model_exp));
        exp_incr = 1'b0;
        exp_decr = 1'b0;
    endtask

    // Driver: run one frame; optional noise on buttons/init mid-frame
    task automatic run_frame(input bit noise);
        int t;
        int cnt;
        t = model_exp + N_ROWS * (ADC_CYC + 1);
        for (int k = 1; k <= t; k++) exp_q.push_back(model_vec(k, model_exp));
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        for (int j = 1; j <= t - 2; j++) begin
            if (noise) begin
                init     = 1'($urandom_range(0, 1));
                exp_incr = 1'($urandom_range(0, 1));
                exp_decr = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        init = 1'b0;
        exp_incr = 1'b0;
        exp_decr = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        check("frame_end_busy", 32'(busy), 32'd0);
        check("frame_exp_kept", 32'(exp_time), 32'(model_exp));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        init = 1'b0;
        exp_incr = 1'b0;
        exp_decr = 1'b0;
        model_exp = EXP_DEFAULT;
        repeat (3) @(negedge clk);
        check("rst_nre", 32'(nre), 32'(2'b11));
        check("rst_expose", 32'(expose), 32'd0);
        check("rst_erase", 32'(erase), 32'd1);
        check("rst_adc", 32'(adc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_exp", 32'(exp_time), 32'(EXP_DEFAULT));
        reset = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);

        run_frame(1'b0);                 // default E=14, done at 26
        hold_buttons(1'b1, 1'b0, 20);    // saturate at 30
        run_frame(1'b1);
        hold_buttons(1'b0, 1'b1, 40);    // saturate at 2
        run_frame(1'b1);
        hold_buttons(1'b1, 1'b1, 5);     // both: hold
        hold_buttons(1'b1, 1'b0, 18);    // 20 -> done at 32
        run_frame(1'b1);

        for (int i = 0; i < 4; i++) begin
            hold_buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(1, 12));
            run_frame(1'b1);
        end

        // Reset mid-frame
        sb_en = 1'b0;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_exp = EXP_DEFAULT;
        check("abort_nre", 32'(nre), 32'(2'b11));
        check("abort_expose", 32'(expose), 32'd0);
        check("abort_erase", 32'(erase), 32'd1);
        check("abort_exp", 32'(exp_time), 32'(EXP_DEFAULT));
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        sb_en = 1'b1;
        run_frame(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
